// File: rtl/counter_arbiter_pkg.sv
// Shared constants for the counter arbiter: FSM encoding and default sizing.
package counter_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_MAX_CYCLES = 16;
  localparam int unsigned DEF_CW         = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester-side bus of the counter arbiter.
// master = requester logic, slave = arbiter.
interface counter_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] w_in;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               hit;
  logic [2:0]         result_state;
  logic               busy;

  modport master (
    output req, w_in,
    input  grant, done, hit, result_state, busy
  );

  modport slave (
    input  req, w_in,
    output grant, done, hit, result_state, busy
  );

endinterface

// File: rtl/counter_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set req bit at or after
// 'start', wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // Scan NUM_REQ positions beginning at start; first hit wins.
  always_comb begin
    int unsigned k;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(start) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin controller sharing one external 3-bit sequence counter among
// NUM_REQ requesters. Each session: grant, clear counter, steer w, report.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic                clock,
  input  logic                reset,
  counter_arbiter_if.slave    bus,
  output logic                cnt_reset,
  output logic                cnt_w,
  input  logic [2:0]          cnt_state,
  input  logic                cnt_trigger
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         state;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      run_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [IW-1:0]      ptr_next;
  logic               run_exit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req    (bus.req),
    .start  (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Search start after the current winner, wrapping past the last requester.
  always_comb begin
    ptr_next = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Any RUN exit condition; hit is decided separately by trigger priority.
  always_comb begin
    run_exit = cnt_trigger || !bus.req[winner] || (run_cnt == CW'(MAX_CYCLES - 1));
  end

  // Only the winner's w reaches the counter, and only while running.
  always_comb begin
    cnt_w = (state == ST_RUN) ? bus.w_in[winner] : 1'b0;
  end

  // Session FSM and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      bus.grant        <= '0;
      bus.done         <= '0;
      bus.hit          <= 1'b0;
      bus.result_state <= '0;
      bus.busy         <= 1'b0;
      cnt_reset        <= 1'b1;
      ptr              <= '0;
      winner           <= '0;
      run_cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done  <= '0;
          cnt_reset <= 1'b0;
          if (pick_valid) begin
            bus.grant <= pick_onehot;
            winner    <= pick_idx;
            bus.busy  <= 1'b1;
            cnt_reset <= 1'b1;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_reset <= 1'b0;
          run_cnt   <= '0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (run_exit) begin
            bus.done         <= bus.grant;
            bus.hit          <= cnt_trigger;
            bus.result_state <= cnt_state;
            bus.grant        <= '0;
            ptr              <= ptr_next;
            state            <= ST_DONE;
          end
        end
        default: begin
          bus.done <= '0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed-vector bench for counter_arbiter; counter side driven directly.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_reset;
  logic       cnt_w;
  logic [2:0] cnt_state;
  logic       cnt_trigger;

  int n_vec = 0;
  int n_err = 0;

  counter_arbiter_if #(.NUM_REQ(4)) bus ();

  counter_arbiter #(
    .NUM_REQ    (4),
    .MAX_CYCLES (16),
    .CW         (5)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .cnt_reset   (cnt_reset),
    .cnt_w       (cnt_w),
    .cnt_state   (cnt_state),
    .cnt_trigger (cnt_trigger)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic cr);
    chk({tag, ".grant"},     32'(bus.grant), 32'(g));
    chk({tag, ".done"},      32'(bus.done),  32'(d));
    chk({tag, ".busy"},      32'(bus.busy),  32'(b));
    chk({tag, ".cnt_reset"}, 32'(cnt_reset), 32'(cr));
  endtask

  initial begin
    logic [3:0] exp;
    rst         = 1'b1;
    bus.req     = 4'b1111;
    bus.w_in    = 4'b0000;
    cnt_state   = 3'd0;
    cnt_trigger = 1'b0;

    // reset held two cycles with all requests pending
    tick(); chk_bus("rst1", 4'b0000, 4'b0000, 1'b0, 1'b1);
    tick(); chk_bus("rst2", 4'b0000, 4'b0000, 1'b0, 1'b1);
    rst = 1'b0;

    // all four hold req: round-robin order 0,1,2,3,0, trigger ends each session
    for (int s = 0; s < 5; s++) begin
      exp = 4'(1 << (s % 4));
      tick(); chk_bus("rr_grant", exp, 4'b0000, 1'b1, 1'b1);
      tick(); chk_bus("rr_run", exp, 4'b0000, 1'b1, 1'b0);
      cnt_trigger = 1'b1;
      cnt_state   = 3'(s);
      tick(); chk_bus("rr_done", 4'b0000, exp, 1'b1, 1'b0);
      chk("rr_hit", 32'(bus.hit), 32'd1);
      chk("rr_result", 32'(bus.result_state), 32'(s));
      cnt_trigger = 1'b0;
      tick(); chk_bus("rr_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    bus.req = 4'b0000;
    tick(); chk_bus("idle_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // single requester 2, w steering and trigger capture
    bus.req  = 4'b0100;
    bus.w_in = 4'b0100;
    tick(); chk_bus("r2_grant", 4'b0100, 4'b0000, 1'b1, 1'b1);
    chk("r2_clear_w", 32'(cnt_w), 32'd0);
    tick(); chk_bus("r2_run", 4'b0100, 4'b0000, 1'b1, 1'b0);
    chk("r2_w1", 32'(cnt_w), 32'd1);
    bus.w_in = 4'b1011; #1;
    chk("r2_w0", 32'(cnt_w), 32'd0);
    bus.w_in    = 4'b0100;
    cnt_state   = 3'd5;
    cnt_trigger = 1'b1;
    tick(); chk_bus("r2_done", 4'b0000, 4'b0100, 1'b1, 1'b0);
    chk("r2_hit", 32'(bus.hit), 32'd1);
    chk("r2_result", 32'(bus.result_state), 32'd5);
    chk("r2_done_w", 32'(cnt_w), 32'd0);
    bus.req     = 4'b0000;
    cnt_trigger = 1'b0;
    tick(); chk_bus("r2_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // requester 1 timeout after 16 RUN cycles
    bus.req   = 4'b0010;
    bus.w_in  = 4'b0000;
    cnt_state = 3'd3;
    tick(); chk_bus("to_grant", 4'b0010, 4'b0000, 1'b1, 1'b1);
    tick();
    for (int c = 1; c < 16; c++) begin
      tick(); chk("to_wait.done", 32'(bus.done), 32'd0);
    end
    tick(); chk_bus("to_done", 4'b0000, 4'b0010, 1'b1, 1'b0);
    chk("to_hit", 32'(bus.hit), 32'd0);
    chk("to_result", 32'(bus.result_state), 32'd3);
    bus.req = 4'b0000;
    tick(); chk_bus("to_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // requester 3: drop req and trigger together in RUN cycle 3; req[0] noise
    bus.req = 4'b1000;
    tick(); chk_bus("r3_grant", 4'b1000, 4'b0000, 1'b1, 1'b1);
    tick();
    bus.req = 4'b1001;
    tick(); chk_bus("r3_run2", 4'b1000, 4'b0000, 1'b1, 1'b0);
    tick();
    bus.req     = 4'b0001;
    cnt_trigger = 1'b1;
    cnt_state   = 3'd2;
    tick(); chk_bus("r3_done", 4'b0000, 4'b1000, 1'b1, 1'b0);
    chk("r3_hit", 32'(bus.hit), 32'd1);
    chk("r3_result", 32'(bus.result_state), 32'd2);
    cnt_trigger = 1'b0;
    tick(); chk_bus("r3_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // pointer wrap to requester 0, session ended by release
    tick(); chk_bus("wrap_grant", 4'b0001, 4'b0000, 1'b1, 1'b1);
    tick();
    bus.req   = 4'b0000;
    cnt_state = 3'd6;
    tick(); chk_bus("rel_done", 4'b0000, 4'b0001, 1'b1, 1'b0);
    chk("rel_hit", 32'(bus.hit), 32'd0);
    chk("rel_result", 32'(bus.result_state), 32'd6);

    // reset during RUN of requester 0
    bus.req = 4'b0001;
    tick();
    tick(); chk_bus("r0_grant", 4'b0001, 4'b0000, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick(); chk_bus("abort1", 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("abort_w", 32'(cnt_w), 32'd0);
    tick(); chk_bus("abort2", 4'b0000, 4'b0000, 1'b0, 1'b1);
    rst     = 1'b0;
    bus.req = 4'b1001;
    tick(); chk_bus("ptr_reset", 4'b0001, 4'b0000, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
